num2text: RTL and testbench
===========================

NUM2TEXT -- requirements
Module: num2text

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-002 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-003 The block SHALL have port val, input, 16 bits: unsigned binary value to render as decimal text.
REQ-004 The block SHALL have port in_valid, input, 1 bit: val is presented.
REQ-005 The block SHALL have port in_ready, output, 1 bit: block can accept val.
REQ-006 The block SHALL have port chr, output, 8 bits: ASCII decimal digit, 8'h30..8'h39.
REQ-007 The block SHALL have port out_valid, output, 1 bit: chr is valid.
REQ-008 The block SHALL have port out_ready, input, 1 bit: consumer takes chr.
REQ-009 The block SHALL have port out_last, output, 1 bit: chr is the final digit of the current value.

Function
REQ-010 The block SHALL have three states: IDLE, CONV, EMIT.
REQ-011 in_ready SHALL be 1 only in IDLE.
REQ-012 out_valid SHALL be 1 only in EMIT.
REQ-013 Acceptance: at an edge with in_valid=1 and in_ready=1, the block SHALL capture val, clear a 20-bit BCD register, and enter CONV.
REQ-014 CONV SHALL perform exactly 16 double-dabble steps, one per cycle: add 3 to each BCD nibble >=5, then shift left one bit with the next val MSB.
REQ-015 The 16th step edge SHALL move the block to EMIT, so out_valid first rises 16 cycles after the accepting edge.
REQ-016 Digits SHALL be emitted most-significant first, with leading zeros suppressed and internal zeros kept.
REQ-017 Value 0 SHALL emit a single '0' (8'h30).
REQ-018 At most 5 digits SHALL be emitted (65535 -> "65535").
REQ-019 chr SHALL equal 8'h30 + the current BCD digit.
REQ-020 chr and out_last SHALL be held stable while out_valid=1 and out_ready=0.
REQ-021 An out_valid=1 and out_ready=1 edge SHALL advance to the next digit.
REQ-022 On the handshake of the last digit (out_last=1), the block SHALL return to IDLE; in_ready is 1 in the following cycle.
REQ-023 There SHALL be no overlap between consecutive values: in_valid outside IDLE is ignored and val is not re-sampled.
REQ-024 No output SHALL depend combinationally on in_valid; out_valid SHALL not depend on out_ready.

Reset
REQ-025 rst_n=0 at a clock edge SHALL force IDLE, with in_ready=1, out_valid=0, out_last=0, chr=8'h30, and the BCD register and step counter cleared.
REQ-026 Reset asserted in CONV or EMIT SHALL abort the conversion, and no further digits of that value SHALL be emitted.
REQ-027 Reset SHALL take priority over any simultaneous handshake.

Structure
REQ-028 Package num2text_pkg SHALL hold the state enum, ASCII_ZERO=8'h30, VAL_W=16, NUM_DIGITS=5, and BCD_W=20.
REQ-029 Sub-module nibble2text SHALL be the combinational 4-bit digit -> ASCII map: 0..9 -> 8'h30..8'h39, and any other value -> 8'h3F ('?'), which is unreachable in normal operation.
REQ-030 The block SHALL instantiate nibble2text once, on the selected digit.

Verification
REQ-031 val=0, out_ready=1 SHALL produce one beat chr=8'h30 with out_last=1, and in_ready=1 in the following cycle.
REQ-032 val=65535 SHALL produce chr 8'h36,8'h35,8'h35,8'h33,8'h35, with out_last only on the 5th beat, and the first out_valid exactly 16 cycles after acceptance.
REQ-033 val=1007 SHALL produce '1','0','0','7' (8'h31,8'h30,8'h30,8'h37), with internal zeros present and no leading zero.
REQ-034 val=42 with out_ready=0 for 3 cycles SHALL hold chr=8'h34 with out_valid=1 for 3 cycles, then after out_ready=1 produce 8'h32 with out_last=1.
REQ-035 val=123 with rst_n=0 for one cycle after the '1' beat SHALL give out_valid=0 and in_ready=1 next cycle, and then val=9 SHALL produce a single 8'h39 with out_last=1.
REQ-036 val=5 accepted, then in_valid=1 with val=77 held during CONV/EMIT, SHALL emit only '5' and accept 77 only once back in IDLE.

Source files
------------

// File: rtl/num2text_pkg.sv
// Shared types, widths and double-dabble helpers for the num2text
// binary-to-decimal ASCII renderer.
package num2text_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    EMIT = 2'd2
  } state_e;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam int         VAL_W      = 16;
  localparam int         NUM_DIGITS = 5;
  localparam int         BCD_W      = 20;

  // One double-dabble step: correct every nibble >= 5, then shift in the next bit.
  function automatic logic [BCD_W-1:0] dabble_step(input logic [BCD_W-1:0] bcd,
                                                    input logic bit_in);
    logic [BCD_W-1:0] adj;
    adj = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
      end
    end
    return {adj[BCD_W-2:0], bit_in};
  endfunction

  // Index of the most-significant non-zero digit; 0 when the value is zero.
  function automatic logic [2:0] top_digit(input logic [BCD_W-1:0] bcd);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd0) begin
        idx = 3'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/nibble2text.sv
// Combinational map from one BCD digit to its ASCII character; non-decimal
// codes render as '?'.
module nibble2text
  import num2text_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [7:0] chr_o
);

  always_comb begin
    if (digit_i <= 4'd9) begin
      chr_o = ASCII_ZERO + {4'd0, digit_i};
    end else begin
      chr_o = 8'h3F;
    end
  end

endmodule

// File: rtl/num2text.sv
// Renders a 16-bit unsigned value as decimal ASCII digits, most significant
// first, with leading zeros suppressed, over a valid/ready stream.
module num2text
  import num2text_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [VAL_W-1:0] val,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       chr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
);

  state_e           state_q, state_d;
  logic [VAL_W-1:0] val_q, val_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [3:0]       step_q, step_d;
  logic [2:0]       idx_q, idx_d;
  logic             in_ready_q, out_valid_q, out_last_q;
  logic [7:0]       chr_q;
  logic [3:0]       sel_digit;
  logic [7:0]       sel_chr;

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    bcd_d   = bcd_q;
    step_d  = step_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          val_d   = val;
          bcd_d   = '0;
          step_d  = 4'd0;
          state_d = CONV;
        end else begin
          state_d = IDLE;
        end
      end
      CONV: begin
        bcd_d  = dabble_step(bcd_q, val_q[VAL_W-1]);
        val_d  = {val_q[VAL_W-2:0], 1'b0};
        step_d = step_q + 4'd1;
        if (step_q == 4'd15) begin
          state_d = EMIT;
          idx_d   = top_digit(bcd_d);
        end else begin
          state_d = CONV;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (idx_q == 3'd0) begin
            state_d = IDLE;
          end else begin
            idx_d = idx_q - 3'd1;
          end
        end else begin
          state_d = EMIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Digit selected for the next cycle, so chr can be registered alongside the state.
  always_comb begin
    case (idx_d)
      3'd0:    sel_digit = bcd_d[3:0];
      3'd1:    sel_digit = bcd_d[7:4];
      3'd2:    sel_digit = bcd_d[11:8];
      3'd3:    sel_digit = bcd_d[15:12];
      3'd4:    sel_digit = bcd_d[19:16];
      default: sel_digit = 4'hF;
    endcase
  end

  nibble2text u_nibble2text (
    .digit_i (sel_digit),
    .chr_o   (sel_chr)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      val_q       <= '0;
      bcd_q       <= '0;
      step_q      <= 4'd0;
      idx_q       <= 3'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      chr_q       <= ASCII_ZERO;
    end else begin
      state_q     <= state_d;
      val_q       <= val_d;
      bcd_q       <= bcd_d;
      step_q      <= step_d;
      idx_q       <= idx_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == EMIT);
      out_last_q  <= (state_d == EMIT) && (idx_d == 3'd0);
      chr_q       <= (state_d == EMIT) ? sel_chr : ASCII_ZERO;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign chr       = chr_q;

endmodule

// File: tb/tb_num2text.sv
// Self-checking bench for num2text: directed table, hand-written corner
// sequences and random values checked against a divide-by-ten model.
module tb_num2text;

  typedef logic [7:0] q_t[$];

  typedef struct {
    logic [15:0] v;
    int          n;
    logic [39:0] chars;
    int          pct;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] val = 16'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  chr;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;

  int n_cmp = 0;
  int n_bad = 0;

  num2text dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .val       (val),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .chr       (chr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic q_t model(input int v);
    q_t q;
    int x;
    x = v;
    if (x == 0) q.push_back(8'h30);
    while (x > 0) begin
      q.push_front(8'(8'h30 + x % 10));
      x = x / 10;
    end
    return q;
  endfunction

  // Called at a negedge while idle; returns at the negedge right after the accepting edge.
  task automatic accept(input logic [15:0] v, input logic keep_valid, input logic [15:0] v_after);
    int g;
    g = 0;
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("accept_ready", int'(in_ready), 1);
    val = v;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = keep_valid;
    val = v_after;
  endtask

  task automatic expect_digits(input q_t exp, input int pct, input string tag);
    int k;
    int j;
    int guard;
    k = 0;
    chk($sformatf("%s busy", tag), int'(in_ready), 0);
    while (!out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk($sformatf("%s latency", tag), k, 16);
    j = 0;
    guard = 0;
    while (j < exp.size() && guard < 400) begin
      if (!out_valid) begin
        chk($sformatf("%s valid_drop", tag), 0, 1);
        break;
      end
      out_ready = ($urandom_range(0, 99) < pct);
      chk($sformatf("%s chr[%0d]", tag, j), int'(chr), int'(exp[j]));
      chk($sformatf("%s last[%0d]", tag, j), int'(out_last), int'(j == exp.size() - 1));
      if (out_ready) j++;
      @(negedge clk);
      guard++;
    end
    if (guard >= 400) chk($sformatf("%s timeout", tag), 0, 1);
    out_ready = 1'b0;
    chk($sformatf("%s idle_ready", tag), int'(in_ready), 1);
    chk($sformatf("%s idle_valid", tag), int'(out_valid), 0);
  endtask

  vec_t tbl[$];

  initial begin
    q_t q;
    tbl.push_back('{16'd0,     1, 40'h30_00_00_00_00, 100});
    tbl.push_back('{16'd65535, 5, 40'h36_35_35_33_35, 100});
    tbl.push_back('{16'd1007,  4, 40'h31_30_30_37_00, 100});
    tbl.push_back('{16'd10000, 5, 40'h31_30_30_30_30, 60});
    tbl.push_back('{16'd100,   3, 40'h31_30_30_00_00, 50});
    tbl.push_back('{16'd9,     1, 40'h39_00_00_00_00, 100});
    tbl.push_back('{16'd50,    2, 40'h35_30_00_00_00, 40});

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst in_ready", int'(in_ready), 1);
    chk("rst out_valid", int'(out_valid), 0);
    chk("rst out_last", int'(out_last), 0);
    chk("rst chr", int'(chr), 8'h30);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[t]) begin
      q.delete();
      for (int i = 0; i < tbl[t].n; i++) q.push_back(tbl[t].chars[39-8*i -: 8]);
      accept(tbl[t].v, 1'b0, 16'd0);
      expect_digits(q, tbl[t].pct, $sformatf("tbl%0d", tbl[t].v));
    end

    // Back-pressure holds the first digit of 42.
    accept(16'd42, 1'b0, 16'd0);
    for (int k = 0; k < 40 && !out_valid; k++) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      chk("bp valid", int'(out_valid), 1);
      chk("bp chr", int'(chr), 8'h34);
      chk("bp last", int'(out_last), 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    chk("bp chr4", int'(chr), 8'h34);
    @(negedge clk);
    chk("bp chr2", int'(chr), 8'h32);
    chk("bp last2", int'(out_last), 1);
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp idle", int'(in_ready), 1);

    // Reset in EMIT after the '1' of 123, with a simultaneous handshake.
    accept(16'd123, 1'b0, 16'd0);
    for (int k = 0; k < 40 && !out_valid; k++) @(negedge clk);
    out_ready = 1'b1;
    chk("rs chr1", int'(chr), 8'h31);
    @(negedge clk);
    chk("rs chr2", int'(chr), 8'h32);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rs valid", int'(out_valid), 0);
    chk("rs ready", int'(in_ready), 1);
    chk("rs chr", int'(chr), 8'h30);
    chk("rs last", int'(out_last), 0);
    out_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) chk("rs stray", int'(out_valid), 0);
    end
    accept(16'd9, 1'b0, 16'd0);
    expect_digits(model(9), 100, "rs9");

    // in_valid held with val=77 while 5 is being converted.
    accept(16'd5, 1'b1, 16'd77);
    expect_digits(model(5), 100, "ov5");
    @(negedge clk);
    in_valid = 1'b0;
    expect_digits(model(77), 100, "ov77");

    // Random values against the decimal model.
    for (int r = 0; r < 40; r++) begin
      logic [15:0] rv;
      rv = 16'($urandom_range(0, 65535));
      if (r % 4 == 0) rv = 16'($urandom_range(0, 99));
      accept(rv, 1'b0, 16'd0);
      expect_digits(model(int'(rv)), $urandom_range(30, 100), $sformatf("rnd%0d", rv));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
